// File: rtl/display_pkg.sv
// +--------------------------------------------------------------------+
// | display_pkg                                                        |
// | Shared point layout, flag encodings and scheduler state encoding.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package display_pkg;

  localparam int c_POINT_W   = 64;
  localparam int c_COORD_W   = 16;
  localparam int c_COLOR_W   = 8;
  localparam int c_FLAG_W    = 8;
  localparam int c_MTU_BYTES = c_POINT_W / 8;

  localparam logic [c_FLAG_W-1:0] FLAG_EOF       = 8'h02;
  localparam int                  FLAG_BLANK_BIT = 0;

  typedef struct packed {
    logic [c_FLAG_W-1:0]  flags;
    logic [c_COORD_W-1:0] x;
    logic [c_COORD_W-1:0] y;
    logic [c_COLOR_W-1:0] b;
    logic [c_COLOR_W-1:0] g;
    logic [c_COLOR_W-1:0] r;
  } point_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ARM      = 3'd2,
    WAIT_SPI = 3'd3,
    DWELL    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// +--------------------------------------------------------------------+
// | dwell_timer                                                        |
// | Loadable down-counter; done while the count sits at zero.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dwell_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic             count_in,
  output logic             done_out
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_count <= '0;
    end else if (load_in) begin
      r_count <= value_in;
    end else if (count_in && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done_out = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/point_scheduler.sv
// +--------------------------------------------------------------------+
// | point_scheduler                                                    |
// | Drives galvo SPI starts and RGB PWM duty for one point at a time.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module point_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_W     = 16,
  parameter int BLANK_EXTRA = 64,
  parameter int SPI_TIMEOUT = 1024
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               enable_in,
  input  logic [DWELL_W-1:0] dwell_in,
  input  logic [63:0]        point_in,
  input  logic               point_valid_in,
  output logic               point_ready_out,
  output logic [15:0]        x_data_out,
  output logic [15:0]        y_data_out,
  output logic               x_start_out,
  output logic               y_start_out,
  input  logic               x_busy_in,
  input  logic               y_busy_in,
  output logic [7:0]         r_out,
  output logic [7:0]         g_out,
  output logic [7:0]         b_out,
  output logic               frame_sync_out,
  output logic [15:0]        underrun_count_out,
  output logic               spi_fault_out
);

  // One timer serves both phases, so it must hold the larger of the two spans.
  localparam int c_TW = ((DWELL_W + 1) > ($clog2(SPI_TIMEOUT) + 1)) ?
                        (DWELL_W + 1) : ($clog2(SPI_TIMEOUT) + 1);

  state_t             r_state;
  state_t             w_next_state;
  point_t             w_point;
  logic [15:0]        r_x;
  logic [15:0]        r_y;
  logic [7:0]         r_lat_r;
  logic [7:0]         r_lat_g;
  logic [7:0]         r_lat_b;
  logic               r_blank;
  logic               r_eof;
  logic [DWELL_W-1:0] r_dwell;
  logic [7:0]         r_pwm_r;
  logic [7:0]         r_pwm_g;
  logic [7:0]         r_pwm_b;
  logic               r_frame_sync;
  logic [15:0]        r_underrun;
  logic               r_fault;
  logic               w_accept;
  logic               w_spi_idle;
  logic               w_timer_done;
  logic               w_timer_load;
  logic               w_timer_count;
  logic [c_TW-1:0]    w_timer_value;
  logic [c_TW-1:0]    w_dwell_base;
  logic [c_TW-1:0]    w_dwell_load;
  logic               w_last_dwell;

  assign w_point      = point_t'(point_in);
  assign w_accept     = point_valid_in && point_ready_out;
  assign w_spi_idle   = !x_busy_in && !y_busy_in;
  assign w_last_dwell = (r_state == DWELL) && w_timer_done;

  assign w_dwell_base = (r_dwell == '0) ? c_TW'(1) : c_TW'(r_dwell);
  assign w_dwell_load = w_dwell_base - c_TW'(1) + (r_blank ? c_TW'(BLANK_EXTRA) : '0);

  dwell_timer #(
    .WIDTH (c_TW)
  ) u_dwell_timer (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .load_in  (w_timer_load),
    .value_in (w_timer_value),
    .count_in (w_timer_count),
    .done_out (w_timer_done)
  );

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next_state = START;
      START:    w_next_state = ARM;
      ARM:      w_next_state = WAIT_SPI;
      WAIT_SPI: begin
        if (w_spi_idle)        w_next_state = DWELL;
        else if (w_timer_done) w_next_state = IDLE;
      end
      DWELL:    if (w_timer_done) w_next_state = w_accept ? START : IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing is offered while the block is held.
  always_comb begin
    point_ready_out = 1'b0;
    x_start_out     = 1'b0;
    y_start_out     = 1'b0;
    w_timer_load    = 1'b0;
    w_timer_value   = w_dwell_load;
    w_timer_count   = 1'b0;
    case (r_state)
      IDLE:     point_ready_out = reset_in && enable_in && !r_fault;
      START: begin
        x_start_out = 1'b1;
        y_start_out = 1'b1;
      end
      ARM: begin
        w_timer_load  = 1'b1;
        w_timer_value = c_TW'(SPI_TIMEOUT - 1);
      end
      WAIT_SPI: begin
        w_timer_load  = w_spi_idle;
        w_timer_count = 1'b1;
      end
      DWELL: begin
        point_ready_out = reset_in && enable_in && w_timer_done;
        w_timer_count   = 1'b1;
      end
      default: point_ready_out = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_x          <= '0;
      r_y          <= '0;
      r_lat_r      <= '0;
      r_lat_g      <= '0;
      r_lat_b      <= '0;
      r_blank      <= 1'b0;
      r_eof        <= 1'b0;
      r_dwell      <= '0;
      r_pwm_r      <= '0;
      r_pwm_g      <= '0;
      r_pwm_b      <= '0;
      r_frame_sync <= 1'b0;
      r_underrun   <= '0;
      r_fault      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x     <= w_point.x;
        r_y     <= w_point.y;
        r_lat_r <= w_point.r;
        r_lat_g <= w_point.g;
        r_lat_b <= w_point.b;
        r_blank <= w_point.flags[FLAG_BLANK_BIT];
        r_eof   <= (w_point.flags == FLAG_EOF);
        r_dwell <= dwell_in;
      end
      // Colour is only ever lit while the next cycle is a dwell cycle.
      if ((w_next_state == DWELL) && !r_blank) begin
        r_pwm_r <= r_lat_r;
        r_pwm_g <= r_lat_g;
        r_pwm_b <= r_lat_b;
      end else begin
        r_pwm_r <= '0;
        r_pwm_g <= '0;
        r_pwm_b <= '0;
      end
      if (w_last_dwell && r_eof) r_frame_sync <= !r_frame_sync;
      if (w_last_dwell && enable_in && !point_valid_in && (r_underrun != 16'hFFFF))
        r_underrun <= r_underrun + 16'd1;
      if ((r_state == WAIT_SPI) && !w_spi_idle && w_timer_done) r_fault <= 1'b1;
    end
  end

  assign x_data_out         = r_x;
  assign y_data_out         = r_y;
  assign r_out              = r_pwm_r;
  assign g_out              = r_pwm_g;
  assign b_out              = r_pwm_b;
  assign frame_sync_out     = r_frame_sync;
  assign underrun_count_out = r_underrun;
  assign spi_fault_out      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_point_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_point_scheduler                                                 |
// | Directed self-checking bench with a simple SPI busy model.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_point_scheduler;

  logic        clock_in;
  logic        reset_in;
  logic        enable_in;
  logic [15:0] dwell_in;
  logic [63:0] point_in;
  logic        point_valid_in;
  logic        point_ready_out;
  logic [15:0] x_data_out;
  logic [15:0] y_data_out;
  logic        x_start_out;
  logic        y_start_out;
  logic        x_busy_in;
  logic        y_busy_in;
  logic [7:0]  r_out;
  logic [7:0]  g_out;
  logic [7:0]  b_out;
  logic        frame_sync_out;
  logic [15:0] underrun_count_out;
  logic        spi_fault_out;

  point_scheduler u_dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .enable_in          (enable_in),
    .dwell_in           (dwell_in),
    .point_in           (point_in),
    .point_valid_in     (point_valid_in),
    .point_ready_out    (point_ready_out),
    .x_data_out         (x_data_out),
    .y_data_out         (y_data_out),
    .x_start_out        (x_start_out),
    .y_start_out        (y_start_out),
    .x_busy_in          (x_busy_in),
    .y_busy_in          (y_busy_in),
    .r_out              (r_out),
    .g_out              (g_out),
    .b_out              (b_out),
    .frame_sync_out     (frame_sync_out),
    .underrun_count_out (underrun_count_out),
    .spi_fault_out      (spi_fault_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          start_q[$];
  int          start_mm;
  int          col_cyc;
  logic [23:0] last_rgb;
  int          fs_tog;
  int          fs_cyc;
  int          ur_cyc;
  int          fault_cyc;
  logic        prev_fs;
  logic [15:0] prev_ur;
  logic        prev_fault;
  int          spi_cycles;
  int          spi_cnt;
  logic        stuck_x;
  int          last_accept;
  logic [63:0] pts [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    start_q.delete();
    start_mm  = 0;
    col_cyc   = 0;
    last_rgb  = '0;
    fs_tog    = 0;
    fs_cyc    = 0;
    ur_cyc    = 0;
    fault_cyc = 0;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    wait_cycles(2);
    reset_in = 1'b1;
    tick();
  endtask

  function automatic logic [63:0] mkpt(input logic [7:0] f, input logic [15:0] x,
                                       input logic [15:0] y, input logic [7:0] r,
                                       input logic [7:0] g, input logic [7:0] b);
    return {f, x, y, b, g, r};
  endfunction

  task automatic send(input logic [63:0] p, input logic [15:0] d);
    int k;
    point_in       = p;
    dwell_in       = d;
    point_valid_in = 1'b1;
    #1;
    k = 0;
    while (!point_ready_out && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) check("send_ready_timeout", 32'd0, 32'd1);
    last_accept = cyc + 1;
    tick();
    point_valid_in = 1'b0;
  endtask

  // Output monitor and SPI busy model, both on the falling edge.
  initial begin
    cyc        = 0;
    spi_cnt    = 0;
    x_busy_in  = 1'b0;
    y_busy_in  = 1'b0;
    prev_fs    = 1'b0;
    prev_ur    = '0;
    prev_fault = 1'b0;
    forever begin
      @(negedge clock_in);
      cyc++;
      if (x_start_out && y_start_out) start_q.push_back(cyc);
      if (x_start_out != y_start_out) start_mm++;
      if (r_out != 0 || g_out != 0 || b_out != 0) begin
        col_cyc++;
        last_rgb = {b_out, g_out, r_out};
      end
      if (frame_sync_out != prev_fs) begin
        fs_tog++;
        fs_cyc = cyc;
      end
      prev_fs = frame_sync_out;
      if (underrun_count_out != prev_ur) ur_cyc = cyc;
      prev_ur = underrun_count_out;
      if (spi_fault_out && !prev_fault) fault_cyc = cyc;
      prev_fault = spi_fault_out;
      if (x_start_out) spi_cnt = spi_cycles;
      else if (spi_cnt > 0) spi_cnt--;
      x_busy_in = (spi_cnt > 0) || stuck_x;
      y_busy_in = (spi_cnt > 0);
    end
  end

  initial begin
    int idx;
    int rdy;
    int ur_before;
    reset_in       = 1'b0;
    enable_in      = 1'b1;
    dwell_in       = '0;
    point_in       = '0;
    point_valid_in = 1'b0;
    spi_cycles     = 5;
    stuck_x        = 1'b0;
    clr();
    wait_cycles(3);

    check("rst_ready", point_ready_out, 0);
    check("rst_xdata", x_data_out, 0);
    check("rst_ydata", y_data_out, 0);
    check("rst_start", {x_start_out, y_start_out}, 0);
    check("rst_rgb", {r_out, g_out, b_out}, 0);
    check("rst_fsync", frame_sync_out, 0);
    check("rst_underrun", underrun_count_out, 0);
    check("rst_fault", spi_fault_out, 0);
    reset_in = 1'b1;
    tick();
    clr();

    // Single point
    send(mkpt(8'h00, 16'h1234, 16'h8000, 8'd10, 8'd20, 8'd30), 16'd8);
    wait_cycles(30);
    check("single_nstart", start_q.size(), 1);
    check("single_start_lat", (start_q.size() > 0) ? start_q[0] - last_accept : 0, 1);
    check("single_xdata", x_data_out, 16'h1234);
    check("single_ydata", y_data_out, 16'h8000);
    check("single_rgb", last_rgb, {8'd30, 8'd20, 8'd10});
    check("single_col_len", col_cyc, 8);
    check("single_dark_after", {r_out, g_out, b_out}, 0);
    check("single_underrun", underrun_count_out, 1);

    // Back-to-back stream
    do_reset();
    clr();
    pts[0] = mkpt(8'h00, 16'd1, 16'd11, 8'd1, 8'd1, 8'd1);
    pts[1] = mkpt(8'h00, 16'd2, 16'd12, 8'd2, 8'd2, 8'd2);
    pts[2] = mkpt(8'h00, 16'd3, 16'd13, 8'd3, 8'd3, 8'd3);
    point_in       = pts[0];
    dwell_in       = 16'd4;
    point_valid_in = 1'b1;
    #1;
    idx = 0;
    for (int i = 0; i < 100 && idx < 3; i++) begin
      if (point_ready_out) begin
        idx++;
        tick();
        if (idx < 3) point_in = pts[idx];
      end else begin
        tick();
      end
    end
    point_valid_in = 1'b0;
    check("b2b_accepts", idx, 3);
    check("b2b_underrun_running", underrun_count_out, 0);
    wait_cycles(40);
    check("b2b_nstart", start_q.size(), 3);
    check("b2b_gap1", (start_q.size() > 1) ? start_q[1] - start_q[0] : 0, 10);
    check("b2b_gap2", (start_q.size() > 2) ? start_q[2] - start_q[1] : 0, 10);
    check("b2b_xdata", x_data_out, 16'd3);
    check("b2b_underrun_end", underrun_count_out, 1);
    check("b2b_start_pair", start_mm, 0);

    // Blank point: dark for the full dwell plus settle time
    clr();
    send(mkpt(8'h01, 16'h0100, 16'h0200, 8'd1, 8'd2, 8'd3), 16'd2);
    wait_cycles(90);
    check("blank_dark", col_cyc, 0);
    check("blank_len", (start_q.size() > 0) ? ur_cyc - start_q[0] : 0, 72);
    check("blank_no_fsync", fs_tog, 0);

    // End-of-frame point
    clr();
    send(mkpt(8'h02, 16'h0300, 16'h0400, 8'd9, 8'd9, 8'd9), 16'd2);
    wait_cycles(20);
    check("eof_toggles", fs_tog, 1);
    check("eof_at_end", (start_q.size() > 0) ? fs_cyc - start_q[0] : 0, 8);
    check("eof_col_len", col_cyc, 2);
    check("eof_fsync", frame_sync_out, 1);

    // Zero dwell behaves as one
    clr();
    send(mkpt(8'h00, 16'h0500, 16'h0600, 8'd7, 8'd0, 8'd0), 16'd0);
    wait_cycles(20);
    check("dwell0_len", col_cyc, 1);

    // Enable dropped mid-dwell
    clr();
    ur_before = underrun_count_out;
    send(mkpt(8'h00, 16'h0700, 16'h0800, 8'd5, 8'd6, 8'd7), 16'd8);
    for (int k = 0; k < 20 && r_out == 0; k++) tick();
    enable_in = 1'b0;
    wait_cycles(20);
    check("en_col_len", col_cyc, 8);
    check("en_no_underrun", underrun_count_out, ur_before);
    check("en_ready", point_ready_out, 0);
    check("en_dark", {r_out, g_out, b_out}, 0);
    enable_in = 1'b1;

    // Reset mid-WAIT_SPI clears outputs without a clock edge
    clr();
    spi_cycles = 30;
    send(mkpt(8'h00, 16'hABCD, 16'h4321, 8'd1, 8'd1, 8'd1), 16'd4);
    wait_cycles(4);
    check("prerst_xdata", x_data_out, 16'hABCD);
    check("prerst_underrun", underrun_count_out, 4);
    reset_in = 1'b0;
    #1;
    check("arst_xdata", x_data_out, 0);
    check("arst_ydata", y_data_out, 0);
    check("arst_underrun", underrun_count_out, 0);
    check("arst_fsync", frame_sync_out, 0);
    check("arst_ready", point_ready_out, 0);
    wait_cycles(2);
    reset_in   = 1'b1;
    spi_cycles = 5;
    wait_cycles(40);

    // Stuck SPI busy
    clr();
    stuck_x = 1'b1;
    send(mkpt(8'h00, 16'h0900, 16'h0A00, 8'd4, 8'd4, 8'd4), 16'd2);
    wait_cycles(1040);
    check("stuck_fault", spi_fault_out, 1);
    check("stuck_fault_time", (start_q.size() > 0) ? fault_cyc - start_q[0] : 0, 1026);
    check("stuck_dark", col_cyc, 0);
    point_valid_in = 1'b1;
    rdy = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (point_ready_out) rdy++;
      tick();
    end
    point_valid_in = 1'b0;
    check("stuck_ready", rdy, 0);
    check("stuck_nstart", start_q.size(), 1);
    stuck_x = 1'b0;
    do_reset();
    check("fault_cleared", spi_fault_out, 0);
    check("ready_after_reset", point_ready_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/point_scheduler.md
# point_scheduler

Sequences laser-projector points from the framebuffer read side onto the galvo DAC SPI controllers and the RGB PWM channels. It accepts one 64-bit point at a time over a valid/ready handshake and starts both X and Y SPI transfers together. Once both DACs have finished, it applies the colour and holds it for a programmable dwell time. Blank points are darkened, end-of-frame points toggle frame sync, and the laser is forced dark whenever it stalls, underruns or hits a fault.

## Interface
- DWELL_W, 16, width of dwell_in and dwell counter
- BLANK_EXTRA, 64, extra dwell cycles added to blank points (galvo settle)
- SPI_TIMEOUT, 1024, max cycles to wait for both SPI busy lines to drop
- clock_in  input  1  system clock; one clock domain
- reset_in  input  1  asynchronous, active-low reset
- enable_in  input  1  1 = run; 0 = finish current point, then idle dark
- dwell_in  input  DWELL_W  dwell cycles per point; sampled on acceptance; 0 treated as 1
- point_in  input  64  [63:56] flags, [55:40] x, [39:24] y, [23:16] b, [15:8] g, [7:0] r
- point_valid_in  input  1  point_in is valid
- point_ready_out  output  1  scheduler takes point_in this cycle if valid
- x_data_out, y_data_out  output  16  DAC codes; stable from START until next acceptance
- x_start_out, y_start_out  output  1  one-cycle SPI start pulses, always coincident
- x_busy_in, y_busy_in  input  1  SPI controller busy
- r_out, g_out, b_out  output  8  PWM duty values
- frame_sync_out  output  1  toggles once per end-of-frame point
- underrun_count_out  output  16  saturating count of starved dwell ends
- spi_fault_out  output  1  sticky; set on SPI timeout, cleared only by reset

## Operation
- Flags: byte value 8'h02 means end-of-frame (EOF); bit 0 means blank. Other bits are ignored.
- States: IDLE, START, ARM, WAIT_SPI, DWELL.
- IDLE:
  - point_ready_out = enable_in && !spi_fault_out.
  - On accept: latch x, y, colour, flags and dwell, then go to START.
- START: x_start_out = y_start_out = 1 for exactly one cycle, then go to ARM.
- ARM: one-cycle guard so the SPI busy lines can rise, then go to WAIT_SPI.
- WAIT_SPI:
  - When x_busy_in and y_busy_in are both 0, load the colour outputs and go to DWELL.
  - Colour outputs are the latched colour, or 0 for a blank point.
- DWELL:
  - Counts from 0 to D-1.
  - D = max(dwell,1), plus BLANK_EXTRA for a blank point.
- Last DWELL cycle:
  - If the point is EOF, toggle frame_sync_out.
  - point_ready_out = enable_in. An accept here goes straight to START, which gives back-to-back points.
  - If enable_in = 1 and point_valid_in = 0: underrun_count_out +1 (saturates at 16'hFFFF), colour outputs go to 0, go to IDLE.
  - If enable_in = 0: colour outputs go to 0, go to IDLE, no underrun is counted.
- SPI timeout:
  - A counter in WAIT_SPI reaches SPI_TIMEOUT.
  - Set spi_fault_out, force colour to 0, go to IDLE.
  - No further points are accepted until reset.
- Colour outputs are 0 in every state except DWELL.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE; all data, start, colour and ready outputs 0.
  - frame_sync_out 0, underrun_count_out 0, spi_fault_out 0.
- Reset asserted mid-operation: outputs clear immediately, with no waiting for the SPI controllers.
- Latency, accept at cycle T: start pulses at T+1, ARM at T+2, earliest busy sampling at T+3.
- Colour becomes valid one cycle after the busy lines are first seen both low.
- frame_sync_out changes on the clock edge that ends DWELL.
- x/y data are registered at acceptance and do not change while the start pulse or either busy line is high.

## Structure
- Package display_pkg holds:
  - point_t, a packed struct matching the point_in layout
  - FLAG_EOF = 8'h02 and FLAG_BLANK_BIT = 0
  - the state_t enum
  - the shared MTU/point width constants
- One sub-module: dwell_timer, a loadable down-counter with a done flag. It is reused for both the dwell count and the SPI timeout.

## Test plan
- Single point: x=16'h1234, y=16'h8000, rgb=(10,20,30), dwell=8, SPI busy for 5 cycles.
  - Required: start pulses at T+1; colour appears once busy has fallen, lasts 8 cycles, then returns to 0.
  - underrun_count_out = 1.
- Back-to-back points: valid held continuously, 3 points, dwell=4.
  - Required: ready high only in IDLE and on the last DWELL cycle; exactly 3 start pulses; underrun count 0 until the stream stops.
- Blank and EOF points, dwell=2.
  - Blank point (flags bit 0 set): rgb stays 0 for 2+64 cycles.
  - EOF point (flags 8'h02): frame_sync_out toggles exactly once, at the dwell end.
- Stuck SPI: x_busy_in held at 1.
  - Required: spi_fault_out set after 1024 WAIT_SPI cycles; colour 0; ready stays 0 until reset.
- Control edge cases:
  - enable_in drops mid-DWELL: the dwell completes, then IDLE dark with no underrun counted.
  - reset_in pulsed low mid-WAIT_SPI: all outputs go to 0 asynchronously.
  - dwell_in = 0: behaves as dwell 1.
